// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//  Shared integer-datapath constants for the decode/writeback blocks.
//  XLEN       : default integer data width
//  NREGS_DEF  : default architectural register count
//  reg_addr_t : register index type for the default register count
//  REG_ZERO   : index of the hard-wired zero register
// ----------------------------------------------------------------------------
package riscv_pkg;
    localparam int XLEN      = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//  One busy flop per architectural register. Issue sets, writeback clears;
//  when both target the same register in one cycle the set wins, since the
//  issuing instruction is the newer producer.
//  clk, reset : clock, synchronous active-high reset
//  issue_en   : set busy[issue_rd] at the edge
//  wr_en      : clear busy[wr_addr] at the edge
//  busy_vec   : registered scoreboard, bit r = register r pending
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (wr_en)
                r_busy[wr_addr] <= 1'b0;
            // Ordered after the clear so a same-register issue leaves it set.
            if (issue_en)
                r_busy[issue_rd] <= 1'b1;
            if (ZERO_R0 != 0)
                r_busy[REG_ZERO] <= 1'b0;
        end
    end

    assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_multiport.sv
// ----------------------------------------------------------------------------
// regfile_multiport
//  Integer register file: NREAD combinational read ports, one write port,
//  optional write-to-read bypass and a per-register busy scoreboard.
//  clk, reset : clock, synchronous active-high reset (clears data and busy)
//  wr_en/wr_addr/wr_data : write port, one cycle latency
//  rd_addr/rd_data       : per-port read index / combinational read data
//  rd_busy               : per-port pending-write flag for rd_addr[i]
//  issue_en/issue_rd     : mark a destination register busy
//  busy_vec              : full scoreboard
// ----------------------------------------------------------------------------
module regfile_multiport
    import riscv_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS   = 32,
    parameter int NREAD   = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [XLEN_P-1:0]           wr_data,
    input  logic [NREAD-1:0][AW-1:0]    rd_addr,
    output logic [NREAD-1:0][XLEN_P-1:0] rd_data,
    output logic [NREAD-1:0]            rd_busy,
    input  logic                        issue_en,
    input  logic [AW-1:0]               issue_rd,
    output logic [NREGS-1:0]            busy_vec
);

    logic [XLEN_P-1:0] r_regs [NREGS];
    logic              w_wr_zero;
    logic              w_wr_commit;

    assign w_wr_zero   = (ZERO_R0 != 0) && (wr_addr == AW'(REG_ZERO));
    assign w_wr_commit = wr_en && !w_wr_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++)
                r_regs[r] <= '0;
        end else if (w_wr_commit) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    regfile_scoreboard #(
        .NREGS   (NREGS),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic w_zero;
        logic w_hit;

        assign w_zero = (ZERO_R0 != 0) && (rd_addr[i] == AW'(REG_ZERO));
        // A bypass hit means the producer is completing right now, so the
        // port sees the new data and no longer reports the register pending.
        assign w_hit  = (BYPASS != 0) && wr_en && (wr_addr == rd_addr[i]) && !w_zero;

        assign rd_data[i] = w_zero ? '0 : (w_hit ? wr_data : r_regs[rd_addr[i]]);
        assign rd_busy[i] = w_hit ? 1'b0 : busy_vec[rd_addr[i]];
    end

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: defaults (XLEN 32, NREGS 32, NREAD 2, BYPASS 1, ZERO_R0 1)
    logic             a_reset, a_wr_en, a_issue_en;
    logic [4:0]       a_wr_addr, a_issue_rd;
    logic [31:0]      a_wr_data;
    logic [1:0][4:0]  a_rd_addr;
    logic [1:0][31:0] a_rd_data;
    logic [1:0]       a_rd_busy;
    logic [31:0]      a_busy_vec;

    // Instance B: NREAD 4, NREGS 16, no bypass
    logic             b_reset, b_wr_en, b_issue_en;
    logic [3:0]       b_wr_addr, b_issue_rd;
    logic [31:0]      b_wr_data;
    logic [3:0][3:0]  b_rd_addr;
    logic [3:0][31:0] b_rd_data;
    logic [3:0]       b_rd_busy;
    logic [15:0]      b_busy_vec;

    regfile_multiport #(.NREGS(32), .NREAD(2), .BYPASS(1), .ZERO_R0(1)) u_a (
        .clk(clk), .reset(a_reset), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .issue_en(a_issue_en), .issue_rd(a_issue_rd),
        .busy_vec(a_busy_vec)
    );

    regfile_multiport #(.NREGS(16), .NREAD(4), .BYPASS(0), .ZERO_R0(1)) u_b (
        .clk(clk), .reset(b_reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .issue_en(b_issue_en), .issue_rd(b_issue_rd),
        .busy_vec(b_busy_vec)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge, then leave settle time before anything is sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_reset = 1'b1; a_wr_en = 1'b0; a_issue_en = 1'b0;
        a_wr_addr = '0; a_issue_rd = '0; a_wr_data = '0; a_rd_addr = '0;
        b_reset = 1'b1; b_wr_en = 1'b0; b_issue_en = 1'b0;
        b_wr_addr = '0; b_issue_rd = '0; b_wr_data = '0; b_rd_addr = '0;
        tick(); tick();
        a_reset = 1'b0; b_reset = 1'b0;
        #1;

        // 1. Reset state: every address on every port reads 0 / not busy.
        chk("a_rst_busy_vec", 64'(a_busy_vec), 64'd0);
        for (int a = 0; a < 32; a++) begin
            a_rd_addr = {5'(a), 5'(31 - a)};
            #1;
            chk("a_rst_rd_data0", 64'(a_rd_data[0]), 64'd0);
            chk("a_rst_rd_data1", 64'(a_rd_data[1]), 64'd0);
            chk("a_rst_rd_busy",  64'(a_rd_busy),    64'd0);
        end

        // 2. Write r5, bypass visible same cycle, stored value next cycle.
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
        a_rd_addr = {5'd5, 5'd5};
        #1;
        chk("a_byp_r5_p0", 64'(a_rd_data[0]), 64'hDEADBEEF);
        chk("a_byp_r5_p1", 64'(a_rd_data[1]), 64'hDEADBEEF);
        tick();
        a_wr_en = 1'b0;
        #1;
        chk("a_rd_r5_p0", 64'(a_rd_data[0]), 64'hDEADBEEF);
        chk("a_rd_r5_p1", 64'(a_rd_data[1]), 64'hDEADBEEF);

        // 3. r0 ignores writes and issues, no bypass on r0.
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h12345678;
        a_issue_en = 1'b1; a_issue_rd = 5'd0;
        a_rd_addr = {5'd5, 5'd0};
        #1;
        chk("a_r0_nobyp", 64'(a_rd_data[0]), 64'd0);
        tick();
        a_wr_en = 1'b0; a_issue_en = 1'b0;
        #1;
        chk("a_r0_rd",       64'(a_rd_data[0]), 64'd0);
        chk("a_r0_busy_vec", 64'(a_busy_vec),   64'd0);

        // 4. Issue r7, busy next cycle, cleared by bypassing write.
        a_issue_en = 1'b1; a_issue_rd = 5'd7; a_rd_addr = {5'd5, 5'd7};
        #1;
        chk("a_issue_same_cyc_busy", 64'(a_rd_busy[0]), 64'd0);
        tick();
        a_issue_en = 1'b0;
        #1;
        chk("a_r7_busy",     64'(a_rd_busy[0]), 64'd1);
        chk("a_r7_busy_vec", 64'(a_busy_vec),   64'h80);
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h55;
        #1;
        chk("a_r7_wr_busy", 64'(a_rd_busy[0]), 64'd0);
        chk("a_r7_wr_data", 64'(a_rd_data[0]), 64'h55);
        tick();
        a_wr_en = 1'b0;
        #1;
        chk("a_r7_after_data", 64'(a_rd_data[0]), 64'h55);
        chk("a_r7_after_busy", 64'(a_busy_vec),   64'd0);

        // 5. Same-register issue+write: busy set, data written.
        a_issue_en = 1'b1; a_issue_rd = 5'd9;
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hAA;
        tick();
        a_issue_en = 1'b0; a_wr_en = 1'b0; a_rd_addr = {5'd4, 5'd9};
        #1;
        chk("a_r9_busy_vec", 64'(a_busy_vec),   64'h200);
        chk("a_r9_data",     64'(a_rd_data[0]), 64'hAA);
        chk("a_r9_rd_busy",  64'(a_rd_busy[0]), 64'd1);
        //    Different registers: issue r3, write r4 (not busy).
        a_issue_en = 1'b1; a_issue_rd = 5'd3;
        a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'h44;
        tick();
        a_issue_en = 1'b0; a_wr_en = 1'b0;
        #1;
        chk("a_r3r4_busy_vec", 64'(a_busy_vec),   64'h208);
        chk("a_r4_data",       64'(a_rd_data[1]), 64'h44);
        //    Re-issue an already-busy register: stays busy, no counting.
        a_issue_en = 1'b1; a_issue_rd = 5'd3;
        tick();
        a_issue_en = 1'b0;
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h33;
        tick();
        a_wr_en = 1'b0;
        #1;
        chk("a_reissue_cleared", 64'(a_busy_vec), 64'h200);

        // 6. Reset overrides concurrent write and issue.
        a_reset = 1'b1; a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hFFFF;
        a_issue_en = 1'b1; a_issue_rd = 5'd12;
        tick();
        a_reset = 1'b0; a_wr_en = 1'b0; a_issue_en = 1'b0;
        a_rd_addr = {5'd9, 5'd5};
        #1;
        chk("a_rst2_busy_vec", 64'(a_busy_vec),   64'd0);
        chk("a_rst2_r5",       64'(a_rd_data[0]), 64'd0);
        chk("a_rst2_r9",       64'(a_rd_data[1]), 64'd0);

        // ---- Instance B: 4 ports, 16 regs, no bypass ----
        chk("b_rst_busy_vec", 64'(b_busy_vec), 64'd0);
        b_wr_en = 1'b1; b_wr_addr = 4'd5; b_wr_data = 32'hDEADBEEF;
        b_rd_addr = {4{4'd5}};
        #1;
        chk("b_nobyp_data", 64'(b_rd_data), 64'd0);
        tick();
        b_wr_en = 1'b0;
        #1;
        for (int p = 0; p < 4; p++)
            chk("b_r5_data", 64'(b_rd_data[p]), 64'hDEADBEEF);

        b_issue_en = 1'b1; b_issue_rd = 4'd7;
        tick();
        b_issue_en = 1'b0; b_rd_addr = {4'd5, 4'd7, 4'd0, 4'd15};
        #1;
        chk("b_r7_busy",     64'(b_rd_busy),  64'b0100);
        chk("b_r7_busy_vec", 64'(b_busy_vec), 64'h80);
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 32'h55;
        #1;
        chk("b_r7_wr_busy", 64'(b_rd_busy),    64'b0100);
        chk("b_r7_wr_old",  64'(b_rd_data[2]), 64'd0);
        tick();
        b_wr_en = 1'b0;
        #1;
        chk("b_r7_data",      64'(b_rd_data[2]), 64'h55);
        chk("b_r7_busy_done", 64'(b_rd_busy),    64'd0);
        chk("b_r15_data",     64'(b_rd_data[0]), 64'd0);

        b_issue_en = 1'b1; b_issue_rd = 4'd9;
        tick();
        b_reset = 1'b1; b_wr_en = 1'b1; b_wr_addr = 4'd2; b_wr_data = 32'h77;
        b_issue_en = 1'b1; b_issue_rd = 4'd12;
        tick();
        b_reset = 1'b0; b_wr_en = 1'b0; b_issue_en = 1'b0;
        #1;
        chk("b_rst2_busy_vec", 64'(b_busy_vec), 64'd0);
        for (int a = 0; a < 16; a++) begin
            b_rd_addr = {4'(a), 4'(a + 1), 4'(a + 2), 4'(a + 3)};
            #1;
            chk("b_rst2_data", 64'(b_rd_data), 64'd0);
            chk("b_rst2_busy", 64'(b_rd_busy), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
